// File: rtl/wb_daq_sram_writer.sv
// Round-robin writer from four DAQ channels into one single-port SRAM.
// Each channel owns a quarter of the SRAM as a ring buffer addressed by its own write pointer.
module wb_daq_sram_writer #(
  parameter int dw = 32,
  parameter int aw = 10
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [3:0]            start_sram,
  input  logic [4*dw-1:0]       data_in,
  output logic [3:0]            grant,
  output logic [3:0]            data_done,
  output logic [aw-1:0]         sram_addr,
  output logic [dw-1:0]         sram_data_out,
  output logic                  sram_we,
  input  logic                  sram_ack,
  output logic [4*(aw-2)-1:0]   wr_ptr,
  output logic [3:0]            wrapped
);

  localparam int pw = aw - 2;
  localparam logic [pw-1:0] ptr_one = pw'(1);

  typedef enum logic [1:0] {IDLE, GRANT, WRITE, DONE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      ch;
  logic [1:0]      rr_last;
  logic [1:0]      pick_ch;
  logic            pick_valid;
  logic [pw-1:0]   ptr_q [4];
  logic [dw-1:0]   chan_word [4];

  for (genvar n = 0; n < 4; n++) begin : g_chan
    assign chan_word[n]          = data_in[n*dw +: dw];
    assign wr_ptr[n*pw +: pw]    = ptr_q[n];
  end

  // First requester after the most recently served channel, wrapping mod 4.
  always_comb begin
    // NOTE: every variable written here gets a default before any branch, so no latch is inferred.
    pick_valid = 1'b0;
    pick_ch    = rr_last;
    for (int i = 1; i <= 4; i++) begin
      if (!pick_valid && start_sram[rr_last + 2'(i)]) begin
        pick_valid = 1'b1;
        pick_ch    = rr_last + 2'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!clear && enable && pick_valid) state_nxt = GRANT;
      GRANT:   state_nxt = WRITE;
      WRITE:   if (sram_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      grant         <= '0;
      data_done     <= '0;
      sram_we       <= 1'b0;
      sram_addr     <= '0;
      sram_data_out <= '0;
      wrapped       <= '0;
      rr_last       <= 2'd3;
      ch            <= 2'd0;
      // NOTE: the pointer array is four small registers, not a RAM, so resetting it costs nothing.
      for (int i = 0; i < 4; i++) ptr_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            for (int i = 0; i < 4; i++) ptr_q[i] <= '0;
            wrapped <= '0;
          end else if (enable && pick_valid) begin
            ch    <= pick_ch;
            grant <= 4'b0001 << pick_ch;
          end
        end
        GRANT: begin
          sram_data_out <= chan_word[ch];
          sram_addr     <= {ch, ptr_q[ch]};
          sram_we       <= 1'b1;
        end
        WRITE: begin
          // Address, data and strobe hold until the SRAM acknowledges; no timeout.
          if (sram_ack) begin
            sram_we       <= 1'b0;
            grant         <= '0;
            data_done[ch] <= 1'b1;
            rr_last       <= ch;
            ptr_q[ch]     <= ptr_q[ch] + ptr_one;
            if (&ptr_q[ch]) wrapped[ch] <= 1'b1;
          end
        end
        DONE: data_done <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_daq_sram_writer.sv
// Directed bench for wb_daq_sram_writer: expected writes are queued when requests are driven
// and popped when the DUT raises sram_we; pointer/wrap status is compared against a shadow model.
module tb_wb_daq_sram_writer;

  localparam int dw = 32;
  localparam int aw = 10;
  localparam int pw = aw - 2;

  logic              wb_clk = 1'b0;
  logic              wb_rst;
  logic              enable;
  logic              clear;
  logic [3:0]        start_sram;
  logic [4*dw-1:0]   data_in;
  logic [3:0]        grant;
  logic [3:0]        data_done;
  logic [aw-1:0]     sram_addr;
  logic [dw-1:0]     sram_data_out;
  logic              sram_we;
  logic              sram_ack;
  logic [4*pw-1:0]   wr_ptr;
  logic [3:0]        wrapped;

  typedef struct packed {
    logic [3:0]    grant;
    logic [aw-1:0] addr;
    logic [dw-1:0] data;
  } exp_t;

  exp_t            sb[$];
  logic [pw-1:0]   sched_ptr [4];
  logic [3:0]      sched_wrapped;
  int              checks = 0;
  int              errors = 0;

  wb_daq_sram_writer #(.dw(dw), .aw(aw)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable), .clear(clear),
    .start_sram(start_sram), .data_in(data_in), .grant(grant), .data_done(data_done),
    .sram_addr(sram_addr), .sram_data_out(sram_data_out), .sram_we(sram_we),
    .sram_ack(sram_ack), .wr_ptr(wr_ptr), .wrapped(wrapped)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed time=%0t required=finish before limit", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge wb_clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*pw-1:0] model_ptrs();
    logic [4*pw-1:0] r;
    for (int n = 0; n < 4; n++) r[n*pw +: pw] = sched_ptr[n];
    return r;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 4; n++) sched_ptr[n] = '0;
    sched_wrapped = '0;
  endtask

  task automatic set_data(input int c, input logic [dw-1:0] d);
    data_in[c*dw +: dw] = d;
  endtask

  task automatic push_exp(input int c, input logic [dw-1:0] d);
    exp_t e;
    logic [1:0] c2;
    c2      = c[1:0];
    e.grant = 4'b0001 << c;
    e.addr  = {c2, sched_ptr[c]};
    e.data  = d;
    sb.push_back(e);
    if (&sched_ptr[c]) sched_wrapped[c] = 1'b1;
    sched_ptr[c] = sched_ptr[c] + 1'b1;
  endtask

  // Waits for the write strobe, checks it against the scoreboard head, acks after
  // 'delay' extra cycles, then checks the single data_done pulse.
  task automatic serve(input int delay, input logic [3:0] next_req);
    exp_t e;
    int   waited = 0;
    while (sram_we !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    if (sram_we !== 1'b1) begin
      check("we_timeout", {63'd0, sram_we}, 64'd1);
      return;
    end
    if (sb.size() == 0) begin
      check("unexpected_write", {63'd0, sram_we}, 64'd0);
      return;
    end
    e = sb.pop_front();
    check("wr_grant", grant, e.grant);
    check("wr_addr", sram_addr, e.addr);
    check("wr_data", sram_data_out, e.data);
    sram_ack = (delay == 0);
    for (int k = 0; k < delay; k++) begin
      step();
      check("hold_we", {63'd0, sram_we}, 64'd1);
      check("hold_addr", sram_addr, e.addr);
      check("hold_data", sram_data_out, e.data);
      check("hold_done", data_done, 64'd0);
    end
    sram_ack = 1'b1;
    step();
    check("done_pulse", data_done, e.grant);
    check("done_we_low", {63'd0, sram_we}, 64'd0);
    check("done_grant_low", grant, 64'd0);
    start_sram = next_req;
    step();
    check("done_single", data_done, 64'd0);
  endtask

  initial begin
    wb_rst     = 1'b0;
    enable     = 1'b0;
    clear      = 1'b0;
    start_sram = '0;
    data_in    = '0;
    sram_ack   = 1'b0;
    model_reset();
    step();
    step();

    // Reset values
    check("rst_grant", grant, 64'd0);
    check("rst_done", data_done, 64'd0);
    check("rst_we", {63'd0, sram_we}, 64'd0);
    check("rst_addr", sram_addr, 64'd0);
    check("rst_data", sram_data_out, 64'd0);
    check("rst_ptr", wr_ptr, 64'd0);
    check("rst_wrapped", wrapped, 64'd0);
    wb_rst = 1'b1;
    step();

    // Single write with ack tied high: grant at t+1, strobe at t+2, done at t+3
    enable   = 1'b1;
    sram_ack = 1'b1;
    set_data(0, 32'hDEADBEEF);
    start_sram = 4'b0001;
    push_exp(0, 32'hDEADBEEF);
    step();
    check("t1_grant", grant, 64'h1);
    check("t1_we_early", {63'd0, sram_we}, 64'd0);
    step();
    check("t1_we", {63'd0, sram_we}, 64'd1);
    serve(0, 4'b0000);
    check("t1_ptr0", wr_ptr[pw-1:0], 64'd1);
    check("t1_ptrs", wr_ptr, model_ptrs());

    // Round robin from reset with all channels requesting
    wb_rst = 1'b0;
    step();
    wb_rst = 1'b1;
    model_reset();
    sb.delete();
    for (int c = 0; c < 4; c++) set_data(c, 32'hA5A5_0000 + c);
    for (int k = 0; k < 5; k++) push_exp(k % 4, 32'hA5A5_0000 + (k % 4));
    start_sram = 4'b1111;
    for (int k = 0; k < 5; k++) serve(0, (k == 4) ? 4'b0000 : 4'b1111);
    check("rr_ptrs", wr_ptr, model_ptrs());

    // Wait states with enable dropped mid-transfer
    sram_ack = 1'b0;
    set_data(1, 32'h1234_5678);
    start_sram = 4'b0010;
    push_exp(1, 32'h1234_5678);
    step();
    check("ws_grant", grant, 64'h2);
    enable = 1'b0;
    serve(3, 4'b0000);
    enable = 1'b1;
    check("ws_ptrs", wr_ptr, model_ptrs());

    // Clear in IDLE, then 256 writes to channel 2 to wrap its region
    clear = 1'b1;
    step();
    step();
    clear = 1'b0;
    model_reset();
    check("clr_ptrs", wr_ptr, 64'd0);
    check("clr_wrapped", wrapped, 64'd0);
    start_sram = 4'b0100;
    for (int k = 0; k < 256; k++) begin
      set_data(2, 32'hC000_0000 + k);
      push_exp(2, 32'hC000_0000 + k);
      serve(0, (k == 255) ? 4'b0000 : 4'b0100);
    end
    check("wrap_flag", wrapped, 64'h4);
    check("wrap_ptr2", wr_ptr[2*pw +: pw], 64'd0);
    check("wrap_model", wrapped, sched_wrapped);
    set_data(2, 32'hC0DE_0200);
    start_sram = 4'b0100;
    push_exp(2, 32'hC0DE_0200);
    serve(0, 4'b0000);

    // Asynchronous reset in the middle of a write
    sram_ack = 1'b0;
    start_sram = 4'b0010;
    for (int k = 0; k < 10 && sram_we !== 1'b1; k++) step();
    check("ar_we_pre", {63'd0, sram_we}, 64'd1);
    sb.delete();
    #2 wb_rst = 1'b0;
    #1;
    check("ar_we", {63'd0, sram_we}, 64'd0);
    check("ar_grant", grant, 64'd0);
    check("ar_ptrs", wr_ptr, 64'd0);
    check("ar_wrapped", wrapped, 64'd0);
    sram_ack = 1'b1;
    step();
    step();
    check("ar_no_done", data_done, 64'd0);
    wb_rst = 1'b1;
    model_reset();
    start_sram = 4'b1111;
    push_exp(0, 32'hA5A5_0000);
    serve(0, 4'b0000);

    // enable low blocks new grants
    enable = 1'b0;
    start_sram = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      step();
      check("en_grant", grant, 64'd0);
      check("en_we", {63'd0, sram_we}, 64'd0);
    end

    // clear during WRITE: transfer completes, then clear wins in IDLE
    enable = 1'b1;
    push_exp(1, 32'h1234_5678);
    step();
    check("cw_grant", grant, 64'h2);
    clear = 1'b1;
    serve(2, 4'b1111);
    check("cw_ptrs_before", wr_ptr, model_ptrs());
    step();
    check("cw_no_grant", grant, 64'd0);
    check("cw_ptrs", wr_ptr, 64'd0);
    check("cw_wrapped", wrapped, 64'd0);
    model_reset();
    clear = 1'b0;
    push_exp(2, 32'hC0DE_0200);
    serve(0, 4'b0000);
    check("cw_final_ptrs", wr_ptr, model_ptrs());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_daq_sram_writer.md
Name: wb_daq_sram_writer

Overview:
- Sits directly downstream of four DAQ channels.
- Consumes each channel's start_sram request and 32-bit data word, and arbitrates among the channels round-robin.
- Writes the granted word into a shared single-port SRAM. Each channel owns a fixed quarter of the SRAM, used as a wrapping ring buffer.
- Returns grant and a data_done pulse to the channel it served.

Parameters:
dw, 32, data width of channel words and SRAM data
aw, 10, SRAM word-address width; each channel region is 2^(aw-2) words

Ports:
wb_clk  input  1  system clock; all logic on rising edge
wb_rst  input  1  reset, asynchronous, active-low
enable  input  1  master enable; low blocks new grants, a transfer in flight completes
clear  input  1  level; resets all write pointers and wrap flags, applied only in IDLE
start_sram  input  4  per-channel request (bit n = channel n), level, held until data_done
data_in  input  4*dw  channel n word on bits [n*dw +: dw], valid while grant[n]
grant  output  4  one-hot grant to the channel being served
data_done  output  4  one-cycle pulse to the served channel on write completion
sram_addr  output  aw  SRAM word address
sram_data_out  output  dw  SRAM write data
sram_we  output  1  write strobe, held until sram_ack
sram_ack  input  1  SRAM write acknowledge, sampled while sram_we=1
wr_ptr  output  4*(aw-2)  per-channel next write offset (status)
wrapped  output  4  sticky per-channel flag: region wrapped at least once

Behaviour:
- Reset (wb_rst=0, async) values: state IDLE; grant=0; data_done=0; sram_we=0; sram_addr=0; sram_data_out=0; all wr_ptr=0; wrapped=0; rr_last=3, so channel 0 has first priority.
- All outputs are registered.
- FSM states: IDLE, GRANT, WRITE, DONE.
- IDLE:
  - If clear=1: zero all wr_ptr and wrapped; no arbitration this cycle.
  - Else, if enable=1 and start_sram!=0: pick the first requesting channel searching rr_last+1, rr_last+2, ... (mod 4); set grant one-hot; next state GRANT.
- GRANT, exactly 1 cycle:
  - Capture sram_data_out <= data_in[ch].
  - Set sram_addr <= {ch[1:0], wr_ptr[ch]}.
  - Assert sram_we <= 1.
  - Next state WRITE.
  - grant stays high.
- WRITE:
  - sram_we, sram_addr and sram_data_out are held stable.
  - On the cycle sram_ack=1: deassert sram_we and grant; pulse data_done[ch]=1; set rr_last=ch; increment wr_ptr[ch] mod 2^(aw-2); next state DONE.
  - If wr_ptr[ch] was all-ones before the increment, set wrapped[ch]=1.
  - Writes have no timeout; sram_we waits indefinitely for sram_ack.
- DONE, 1 cycle:
  - data_done returns to 0.
  - Next state IDLE. This gives the channel one cycle to drop or re-raise start_sram.
- Latency:
  - Request seen in IDLE at cycle t: grant at t+1, sram_we at t+2.
  - With sram_ack at t+2: data_done at t+3, next grant no earlier than t+5.
- Exactly one word is written per grant.
- A channel that keeps start_sram high is re-served only after the other requesters, in rotation.
- start_sram changes while the block is not in IDLE are ignored.
- A deasserted request in IDLE is never granted.
- enable dropping in GRANT or WRITE does not abort the transfer.
- clear asserted outside IDLE is ignored until the FSM returns to IDLE. If clear is still high then, it wins over arbitration.
- If sram_ack is high in GRANT it is ignored; only ack while in WRITE counts.
- The same channel's pointer is never updated twice for one grant.
- wr_ptr overwrites the oldest data on wrap; the block keeps no overflow backpressure, and wrapped reports the condition.
- Reset mid-transfer: immediate return to reset values; the partially written word is abandoned and no data_done is issued.

Test Plan:
- Single write: reset, enable=1, start_sram=4'b0001, data_in[0]=32'hDEADBEEF, sram_ack tied 1 -> grant=0001 at t+1; sram_we=1, sram_addr=0x000, data=DEADBEEF at t+2; data_done=0001 one cycle at t+3; wr_ptr[0]=1.
- Round robin: start_sram=4'b1111 held, ack=1 -> grant order 0001,0010,0100,1000,0001; addresses 0x000,0x100,0x200,0x300,0x001.
- SRAM wait states: ack delayed 3 cycles after sram_we -> sram_we, addr and data stable for 4 cycles; a single data_done pulse; wr_ptr increments once.
- Wrap: issue 256 writes to channel 2 (aw=10) -> last address 0x2FF; wrapped=0100; wr_ptr[2]=0; next write address 0x200.
- Control: enable=0 with requests pending -> no grant. clear=1 during WRITE -> transfer completes, then pointers and wrapped are zeroed in IDLE and no grant issues that cycle.
- Async reset: wb_rst driven low mid-WRITE between clock edges -> sram_we, grant, wr_ptr and wrapped are 0 immediately; no data_done; after release, channel 0 has priority.
